// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial adder/subtractor, one bit per clock LSB first, with a
//            start/busy/done handshake and carry/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               w_bit;
  logic               w_cout;
  logic [WIDTH-1:0]   w_shift;

  // op_a doubles as the result register: each sum bit enters at the MSB as
  // the consumed operand bit leaves at the LSB.
  assign w_bit   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign w_cout  = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  assign w_shift = (op_a_q >> 1) | (WIDTH'(w_bit) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        op_a_d  = w_shift;
        op_b_d  = op_b_q >> 1;
        carry_d = w_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = w_shift;
          cout_d  = w_cout;
          ovf_d   = carry_q ^ w_cout;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    bit          cout;
    bit          ovf;
    int          k;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, sub1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  int   cyc;
  int   checks;
  int   failures;
  exp_t q8[$];
  exp_t q1[$];
  logic [7:0] held8;
  logic [0:0] held1;
  int   run8, run1;
  bit   rst_chk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain modular arithmetic for the result/carry, signed integer
  // range test for overflow.
  function automatic exp_t model(input int w, input longint ua, input longint ub,
                                 input bit s, input int k);
    exp_t   e;
    longint mask, full, sa, sb, sr, smax, smin;
    mask = (64'sd1 <<< w) - 1;
    full = s ? (ua + ((~ub) & mask) + 1) : (ua + ub);
    sa   = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
    sb   = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
    sr   = s ? (sa - sb) : (sa + sb);
    smax = (64'sd1 <<< (w - 1)) - 1;
    smin = -(64'sd1 <<< (w - 1));
    e.sum  = 32'(full & mask);
    e.cout = ((full >>> w) & 1) != 0;
    e.ovf  = (sr > smax) || (sr < smin);
    e.k    = k;
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    if (rst) begin
      held8 = '0; held1 = '0; run8 = 0; run1 = 0;
    end else begin
      if (done8) begin
        if (q8.size() == 0) chk("unexpected_done8", 1, 0);
        else begin
          e = q8.pop_front();
          chk("sum8", sum8, e.sum);
          chk("cout8", cout8, e.cout);
          chk("ovf8", ovf8, e.ovf);
          chk("latency8", cyc, e.k + 8);
          chk("busy_len8", run8, 8);
          held8 = e.sum[7:0];
        end
        run8 = 0;
      end else if (busy8) begin
        run8++;
        chk("held_sum8", sum8, held8);
      end else run8 = 0;

      if (done1) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("sum1", sum1, e.sum);
          chk("cout1", cout1, e.cout);
          chk("ovf1", ovf1, e.ovf);
          chk("latency1", cyc, e.k + 1);
          chk("busy_len1", run1, 1);
          held1 = e.sum[0:0];
        end
        run1 = 0;
      end else if (busy1) begin
        run1++;
        chk("held_sum1", sum1, held1);
      end else run1 = 0;

      if (rst_chk) begin
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_sum1", sum1, 0);
      end
    end
  endtask

  // Called just after a rising edge; start is sampled at the following edge.
  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input bit is);
    q8.push_back(model(8, longint'(ia), longint'(ib), is, cyc + 1));
    start8 = 1'b1; a8 = ia; b8 = ib; sub8 = is;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue1(input logic ia, input logic ib, input bit is);
    q1.push_back(model(1, longint'(ia), longint'(ib), is, cyc + 1));
    start1 = 1'b1; a1 = ia; b1 = ib; sub1 = is;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); sub1 = 1'($urandom);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (q8.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    if (q8.size() != 0) begin
      chk("timeout8", q8.size(), 0);
      q8.delete();
    end
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (q1.size() != 0 && n < 10) begin @(posedge clk); #1; n++; end
    if (q1.size() != 0) begin
      chk("timeout1", q1.size(), 0);
      q1.delete();
    end
  endtask

  task automatic reset_pulse(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0; rst_chk = 1'b1;
    @(posedge clk); #1;
    rst_chk = 1'b0;
  endtask

  task automatic driver();
    int n;
    logic [7:0] ra, rb;
    reset_pulse(3);

    issue8(8'h05, 8'h03, 1'b0); wait_idle8();
    issue8(8'hFF, 8'h01, 1'b0); wait_idle8();
    issue8(8'h7F, 8'h01, 1'b0); wait_idle8();
    issue8(8'h03, 8'h05, 1'b1); wait_idle8();
    issue8(8'h80, 8'h01, 1'b1); wait_idle8();

    // Start during RUN must be ignored.
    issue8(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1; @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_idle8();
    repeat (3) begin @(posedge clk); #1; end

    // Start asserted in the DONE cycle launches back-to-back.
    issue8(8'h3C, 8'h41, 1'b0);
    n = 0;
    while (!done8 && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_done_seen", done8, 1);
    issue8(8'hA5, 8'h5A, 1'b1);
    wait_idle8();

    // Abort mid-operation: reset sampled at edge k+4.
    issue8(8'hC3, 8'h5A, 1'b0);
    q8.delete();
    repeat (3) begin @(posedge clk); #1; end
    reset_pulse(1);
    repeat (12) begin @(posedge clk); #1; end
    issue8(8'h01, 8'h01, 1'b0); wait_idle8();

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      issue8(ra, rb, 1'($urandom));
      wait_idle8();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    issue1(1'b1, 1'b0, 1'b0); wait_idle1();
    issue1(1'b0, 1'b0, 1'b0); wait_idle1();
    issue1(1'b1, 1'b1, 1'b0); wait_idle1();
    issue1(1'b0, 1'b1, 1'b0); wait_idle1();
    for (int i = 0; i < 8; i++) begin
      issue1(1'($urandom), 1'($urandom), 1'($urandom));
      wait_idle1();
    end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rst_chk = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    held8 = '0; held1 = '0; run8 = 0; run1 = 0;
    fork
      begin
        forever begin
          @(negedge clk);
          mon_step();
        end
      end
      driver();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor. It processes one bit per clock, from LSB to MSB, using a single full-adder cell and a carry flip-flop. It trades latency for area compared with the combinational half/full adder cells. It is driven by a start/busy/done handshake and sits under a small controller or bench that issues operand pairs.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request an operation; sampled only while busy=0
sub  input  1  0 = a+b, 1 = a-b; sampled together with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the result becomes valid
sum  output  WIDTH  result, held until the next completion or reset
carry_out  output  1  carry out of MSB (subtract: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: when rst=1 at a rising edge, the state goes to IDLE; busy, done, sum, carry_out, overflow, the bit counter and the internal carry all clear to 0. rst has priority over start.
- Reset mid-operation: the operation is aborted. No done pulse is produced and the partial result is discarded (sum=0).
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge k:
  - latch a into op_a;
  - latch b into op_b, inverted if sub=1;
  - set carry to sub;
  - set the counter to 0, state -> RUN, busy=1.
- start while busy=1 is ignored. Operands and sub may change freely during RUN.
- RUN, each edge:
  - bit[cnt] = op_a[cnt] ^ op_b[cnt] ^ carry;
  - carry <= majority(op_a[cnt], op_b[cnt], carry);
  - the sum bit goes into an internal shift/result register;
  - cnt increments.
- RUN completion: on the edge processing cnt = WIDTH-1 (edge k+WIDTH):
  - sum <= full result; carry_out <= final carry;
  - overflow <= carry into MSB XOR carry out of MSB;
  - done <= 1, busy <= 0, state -> DONE.
- DONE, next edge: done <= 0. State -> IDLE, or RUN if start=1 (back-to-back). Outputs stay held.
- Latency: busy is high for exactly WIDTH cycles. Results are valid and done=1 from edge k+WIDTH. Minimum start-to-start spacing is WIDTH+1 cycles.
- Outputs hold between operations. sum and flags change only on completion or reset, never during RUN.
- Arithmetic: modulo 2^WIDTH. Subtraction is a + ~b + 1.
- WIDTH=1: single RUN cycle. overflow = carry_in XOR carry_out of bit 0. With sub=0, a single add reproduces the half-adder truth table: sum = a^b, carry_out = a&b.
- Counter width: clog2(WIDTH)+1 bits. No wrap occurs because the counter resets on every start.

Test Plan:
- WIDTH=8, start with a=8'h05, b=8'h03, sub=0 -> busy high 8 cycles; done pulse 1 cycle at edge k+8; sum=8'h08, carry_out=0, overflow=0.
- WIDTH=8, adds: FF+01 -> sum=00, carry_out=1, overflow=0. 7F+01 -> sum=80, carry_out=0, overflow=1.
- WIDTH=8, subtracts: 03-05 -> sum=FE, carry_out=0, overflow=0. 80-01 -> sum=7F, carry_out=1, overflow=1.
- WIDTH=8, start with a=10, b=20; then at k+3 start with a=FF, b=FF -> second start ignored; sum=30 at edge k+8. A start held through DONE launches the next operation immediately.
- WIDTH=8, rst=1 at edge k+4 of a RUN -> next cycle busy=0, done never pulses, sum/flags=0. A subsequent start 01+01 yields sum=02 after 8 cycles.
- WIDTH=1, all four (a,b) combos with sub=0 -> done at edge k+1; (1,0)->s1 c0, (0,0)->s0 c0, (1,1)->s0 c1, (0,1)->s1 c0.
